bar_handshake_tx: RTL and testbench
===================================

Name: bar_handshake_tx

Overview:
- Transmitter end of the `handshake` / `handshake_arr_*` ready/valid interface that the RTL monitor checks.
- Accepts operand pairs `(in1, in2)` from an upstream ready/valid port and buffers them in a small FIFO.
- Forks each buffered entry to four consumer lanes: the primary `handshake` lane and `handshake_arr_0..2`.
- An entry retires only after every lane has accepted it. Lanes may accept in any order and in any cycles.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, 8, width of the retired-entry counter; wraps modulo 2^CNT_W.

Ports:
- CLK  in  1  clock, rising edge.
- ASYNCRESETN  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO contents and fork state.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  upstream may push.
- in1  in  5  operand A.
- in2  in  5  operand B.
- out_data  out  10  head payload {in2, in1}; shared by all lanes.
- out  out  1  head flag = |in1 of the head entry, captured at push.
- handshake_valid  out  1  primary lane valid.
- handshake_ready  in  1  primary lane ready.
- handshake_arr_0_valid / handshake_arr_1_valid / handshake_arr_2_valid  out  1 each  array lane valids.
- handshake_arr_0_ready / handshake_arr_1_ready / handshake_arr_2_ready  in  1 each  array lane readies.
- retired_count  out  CNT_W  number of entries retired since reset, wrapping.
- empty  out  1  FIFO empty.

Behaviour:
- Reset (ASYNCRESETN=0, asynchronous): FIFO empty; sent mask = 4'b0000; retired_count = 0.
- During reset: all lane valids = 0, in_ready = 0, out_data = 0, out = 0, empty = 1.
- First push is allowed on the first clock edge after reset deassertion.
- Upstream side:
  - in_ready = !full, with no bypass; a full FIFO blocks push even if a retire happens in the same cycle.
  - A push occurs when in_valid & in_ready.
  - Stored payload is {in2, in1} plus flag |in1.
- Latency: an entry pushed at edge N is visible on out_data and lane valids from edge N, i.e. usable in cycle N+1. There is no combinational path from in_* to any output.
- Lane k valid = !empty & !sent[k]. Valid never depends on that lane's ready.
- Lane k fires when valid_k & ready_k; fire_k sets sent[k] at the edge.
- Retire condition: (sent | fire) == 4'b1111 at an edge.
  - Pop the head, clear sent to 0, increment retired_count.
  - Multiple lanes may fire in the same cycle; all four firing together retires the entry in one cycle.
- Stability: while any lane valid is high, out_data and out are held until retire.
  - Once a lane has fired, its valid stays low until the next entry is at the head.
- Simultaneous push and retire when neither full nor empty:
  - Count is unchanged.
  - The new head (the next entry, or the just-pushed entry if the FIFO had one entry) is presented the next cycle.
- Pointer wrap-around: read and write pointers are log2(DEPTH) bits and wrap naturally.
  - Full/empty are disambiguated by a separate count register of log2(DEPTH)+1 bits.
- Flush:
  - Has priority over push and over retire.
  - At the edge it empties the FIFO and clears sent.
  - In the flush cycle in_ready is still !full, but no push is recorded.
  - Lane fires in the flush cycle are discarded and do not count.
  - retired_count is unaffected by flush.
- Reset mid-fork: partially sent entries are lost; the sent mask clears asynchronously.
- out_data and out show the head entry whenever the FIFO is not empty, and 0 when empty.

Decomposition:
- Package bar_handshake_pkg:
  - LANES = 4;
  - lane index constants LANE_PRI = 0, LANE_ARR0 = 1, LANE_ARR1 = 2, LANE_ARR2 = 3;
  - typedef payload_t struct {logic [4:0] in2; logic [4:0] in1; logic flag;}.
- One sub-module, bar_handshake_fifo:
  - parameterised DEPTH FIFO with push, pop, flush, full, empty, head;
  - asynchronous active-low reset.
- Fork mask, lane valids and retire logic live in the top.

Test Plan:
- Push in1=5'h03, in2=5'h1F while all readies are held high → one cycle later all four valids are 1, out_data = 10'h3E3, out = 1. Next edge: retire, retired_count = 1, empty = 1.
- Push one entry with in1=0. Fire the lanes one per cycle in order arr2, pri, arr0, arr1 → out = 0. Each lane's valid drops right after it fires. out_data stays stable for 4 cycles. Retire happens on the 4th fire and retired_count increments exactly once.
- Push 5 entries back-to-back with all readies low, DEPTH=4 → in_ready = 0 after the 4th push and the 5th is not accepted. Then raise all readies → 4 retires on consecutive cycles, payloads in push order, retired_count = 4.
- Push 12 entries with readies toggling pseudo-randomly → all pointers wrap. Every lane observes each payload exactly once, in order. retired_count = 12.
- Assert flush after two lanes of a partially sent head have fired → next cycle empty = 1, all valids 0, retired_count unchanged. A subsequent push is presented to all four lanes.
- Drop ASYNCRESETN mid-transfer, away from a clock edge → valids, in_ready and retired_count go to 0 immediately without a clock edge. After release, normal operation resumes with the FIFO empty.

Source files
------------

// File: rtl/bar_handshake_pkg.sv
// rtl/bar_handshake_pkg.sv - shared types and lane constants for the handshake transmitter
package bar_handshake_pkg;

  localparam int LANES     = 4;
  localparam int LANE_PRI  = 0;
  localparam int LANE_ARR0 = 1;
  localparam int LANE_ARR1 = 2;
  localparam int LANE_ARR2 = 3;

  typedef struct packed {
    logic [4:0] in2;
    logic [4:0] in1;
    logic       flag;
  } payload_t;

  // Build a stored entry; the flag is captured at push so the head never recomputes it.
  function automatic payload_t make_payload(input logic [4:0] a, input logic [4:0] b);
    payload_t p;
    p.in2  = b;
    p.in1  = a;
    p.flag = |a;
    return p;
  endfunction

endpackage

// File: rtl/bar_handshake_tx_if.sv
// rtl/bar_handshake_tx_if.sv - upstream port plus four consumer lanes of the transmitter
interface bar_handshake_tx_if;

  logic       in_valid;
  logic       in_ready;
  logic [4:0] in1;
  logic [4:0] in2;

  logic [9:0] out_data;
  logic       out;

  logic       handshake_valid;
  logic       handshake_ready;
  logic       handshake_arr_0_valid;
  logic       handshake_arr_0_ready;
  logic       handshake_arr_1_valid;
  logic       handshake_arr_1_ready;
  logic       handshake_arr_2_valid;
  logic       handshake_arr_2_ready;

  modport master (
    input  in_valid, in1, in2,
    output in_ready,
    output out_data, out,
    output handshake_valid, handshake_arr_0_valid, handshake_arr_1_valid, handshake_arr_2_valid,
    input  handshake_ready, handshake_arr_0_ready, handshake_arr_1_ready, handshake_arr_2_ready
  );

  modport slave (
    output in_valid, in1, in2,
    input  in_ready,
    input  out_data, out,
    input  handshake_valid, handshake_arr_0_valid, handshake_arr_1_valid, handshake_arr_2_valid,
    output handshake_ready, handshake_arr_0_ready, handshake_arr_1_ready, handshake_arr_2_ready
  );

endinterface

// File: rtl/bar_handshake_fifo.sv
// rtl/bar_handshake_fifo.sv - payload FIFO with flush; count register separates full from empty
module bar_handshake_fifo
  import bar_handshake_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     CLK,
  input  logic     ASYNCRESETN,
  input  logic     flush,
  input  logic     push,
  input  payload_t wdata,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output payload_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  payload_t      mem [DEPTH];

  logic push_en;
  logic pop_en;

  // Flush overrides both sides; a full FIFO refuses push even if it pops this cycle.
  always_comb begin
    push_en = push & ~full & ~flush;
    pop_en  = pop & ~empty & ~flush;
  end

  // Pointer and occupancy state; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

  // Status flags and zero-masked head entry.
  always_comb begin
    full  = (count == (AW+1)'(DEPTH));
    empty = (count == '0);
    head  = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/bar_handshake_tx.sv
// rtl/bar_handshake_tx.sv - buffers operand pairs and forks each entry to four ready/valid lanes
module bar_handshake_tx
  import bar_handshake_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  input  logic               flush,
  bar_handshake_tx_if.master hs,
  output logic [CNT_W-1:0]   retired_count,
  output logic               empty
);

  logic             full;
  logic             retire;
  payload_t         head;
  logic [LANES-1:0] sent;
  logic [LANES-1:0] ready_vec;
  logic [LANES-1:0] valid_vec;
  logic [LANES-1:0] fire;

  bar_handshake_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .flush       (flush),
    .push        (hs.in_valid & hs.in_ready),
    .wdata       (make_payload(hs.in1, hs.in2)),
    .pop         (retire),
    .full        (full),
    .empty       (empty),
    .head        (head)
  );

  // Upstream ready is gated by reset so nothing is offered while the block is held in reset.
  assign hs.in_ready = ASYNCRESETN & ~full;

  // Head payload is shared by every lane.
  assign hs.out_data = {head.in2, head.in1};
  assign hs.out      = head.flag;

  // Gather lane readies into a vector indexed by lane number.
  always_comb begin
    ready_vec            = '0;
    ready_vec[LANE_PRI]  = hs.handshake_ready;
    ready_vec[LANE_ARR0] = hs.handshake_arr_0_ready;
    ready_vec[LANE_ARR1] = hs.handshake_arr_1_ready;
    ready_vec[LANE_ARR2] = hs.handshake_arr_2_ready;
  end

  // A lane offers the head until it has taken it; the entry retires once all lanes have it.
  always_comb begin
    valid_vec = {LANES{~empty}} & ~sent;
    fire      = valid_vec & ready_vec;
    retire    = ~empty & ~flush & ((sent | fire) == {LANES{1'b1}});
  end

  // Drive lane valids out through the interface.
  always_comb begin
    hs.handshake_valid       = valid_vec[LANE_PRI];
    hs.handshake_arr_0_valid = valid_vec[LANE_ARR0];
    hs.handshake_arr_1_valid = valid_vec[LANE_ARR1];
    hs.handshake_arr_2_valid = valid_vec[LANE_ARR2];
  end

  // Record which lanes already took the head; cleared on retire, flush or reset.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      sent <= '0;
    end else if (flush || retire) begin
      sent <= '0;
    end else begin
      sent <= sent | fire;
    end
  end

  // Count retired entries; flush does not touch this counter.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      retired_count <= '0;
    end else if (retire) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bar_handshake_tx.sv
// tb/tb_bar_handshake_tx.sv - scoreboard bench for bar_handshake_tx
module tb_bar_handshake_tx;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             ASYNCRESETN;
  logic             flush;
  logic [CNT_W-1:0] retired_count;
  logic             empty;
  logic [3:0]       rdy;
  logic [3:0]       vv;

  bar_handshake_tx_if hs();

  bar_handshake_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK           (CLK),
    .ASYNCRESETN   (ASYNCRESETN),
    .flush         (flush),
    .hs            (hs),
    .retired_count (retired_count),
    .empty         (empty)
  );

  always #5 CLK = ~CLK;

  assign hs.handshake_ready       = rdy[0];
  assign hs.handshake_arr_0_ready = rdy[1];
  assign hs.handshake_arr_1_ready = rdy[2];
  assign hs.handshake_arr_2_ready = rdy[3];
  assign vv = {hs.handshake_arr_2_valid, hs.handshake_arr_1_valid,
               hs.handshake_arr_0_valid, hs.handshake_valid};

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [10:0] lane_q [4][$];
  logic [3:0]  mask;
  int unsigned exp_ret;
  logic        done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every lane transfer pops that lane's expected payload.
  always @(negedge CLK) begin
    if (!ASYNCRESETN) begin
      for (int k = 0; k < 4; k++) lane_q[k].delete();
      mask    = 4'h0;
      exp_ret = 0;
    end else begin
      check("retired_count", {24'h0, retired_count}, {24'h0, exp_ret[7:0]});
      if (flush) begin
        for (int k = 0; k < 4; k++) lane_q[k].delete();
        mask = 4'h0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (vv[k] && rdy[k]) begin
            if (lane_q[k].size() == 0) begin
              check($sformatf("lane%0d unexpected transfer", k), 32'd1, 32'd0);
            end else begin
              logic [10:0] e;
              e = lane_q[k].pop_front();
              check($sformatf("lane%0d payload", k), {21'h0, hs.out_data, hs.out}, {21'h0, e});
            end
            mask[k] = 1'b1;
          end
        end
        if (mask == 4'hF) begin
          exp_ret++;
          mask = 4'h0;
        end
      end
    end
  end

  task automatic push(input logic [4:0] a, input logic [4:0] b);
    int waitc = 0;
    hs.in1      = a;
    hs.in2      = b;
    hs.in_valid = 1'b1;
    forever begin
      @(negedge CLK);
      if (hs.in_ready && !flush) begin
        for (int k = 0; k < 4; k++) lane_q[k].push_back({b, a, |a});
        break;
      end
      waitc++;
      if (waitc > 200) begin
        check("push timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    hs.in_valid = 1'b0;
  endtask

  function automatic bit queues_empty();
    for (int k = 0; k < 4; k++) if (lane_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  int order [4] = '{3, 0, 1, 2};

  initial begin
    logic [3:0] fired;
    ASYNCRESETN = 1'b0;
    flush       = 1'b0;
    rdy         = 4'h0;
    done        = 1'b0;
    hs.in_valid = 1'b0;
    hs.in1      = 5'h0;
    hs.in2      = 5'h0;
    #2;
    check("reset valids", {28'h0, vv}, 32'h0);
    check("reset in_ready", {31'h0, hs.in_ready}, 32'd0);
    check("reset out_data", {22'h0, hs.out_data}, 32'h0);
    check("reset out", {31'h0, hs.out}, 32'd0);
    check("reset empty", {31'h0, empty}, 32'd1);
    check("reset retired", {24'h0, retired_count}, 32'd0);
    #10 ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;

    // Single entry, all readies high
    rdy = 4'hF;
    push(5'h03, 5'h1F);
    @(negedge CLK);
    check("t1 valids", {28'h0, vv}, 32'hF);
    check("t1 out_data", {22'h0, hs.out_data}, 32'h3E3);
    check("t1 out", {31'h0, hs.out}, 32'd1);
    @(posedge CLK); #1;
    check("t1 retired", {24'h0, retired_count}, 32'd1);
    check("t1 empty", {31'h0, empty}, 32'd1);

    // Lanes fire one at a time: arr2, pri, arr0, arr1
    rdy = 4'h0;
    push(5'h00, 5'h0A);
    fired = 4'h0;
    for (int i = 0; i < 4; i++) begin
      rdy = 4'h1 << order[i];
      @(negedge CLK);
      check($sformatf("t2 valids step%0d", i), {28'h0, vv}, {28'h0, ~fired});
      check($sformatf("t2 out_data step%0d", i), {22'h0, hs.out_data}, 32'h140);
      check($sformatf("t2 out step%0d", i), {31'h0, hs.out}, 32'd0);
      check($sformatf("t2 retired step%0d", i), {24'h0, retired_count}, 32'd1);
      @(posedge CLK); #1;
      fired = fired | (4'h1 << order[i]);
    end
    rdy = 4'h0;
    check("t2 retired", {24'h0, retired_count}, 32'd2);
    check("t2 empty", {31'h0, empty}, 32'd1);

    // Fill to full with readies low, fifth push refused
    for (int i = 0; i < 4; i++) push(5'(i + 4), 5'(i + 9));
    check("t3 in_ready full", {31'h0, hs.in_ready}, 32'd0);
    hs.in1 = 5'h15; hs.in2 = 5'h0E; hs.in_valid = 1'b1;
    @(negedge CLK);
    check("t3 fifth refused", {31'h0, hs.in_ready}, 32'd0);
    @(posedge CLK); #1;
    hs.in_valid = 1'b0;
    rdy = 4'hF;
    repeat (4) @(posedge CLK);
    #1;
    check("t3 retired", {24'h0, retired_count}, 32'd6);
    check("t3 empty", {31'h0, empty}, 32'd1);
    rdy = 4'h0;

    // Twelve entries with toggling readies; pointers wrap
    fork
      begin
        for (int i = 0; i < 12; i++) push(5'(i * 3 + 1), 5'(31 - i));
        done = 1'b1;
      end
      begin
        logic [7:0] lf;
        int cyc;
        lf  = 8'hA5;
        cyc = 0;
        while (!(done && queues_empty()) && cyc < 600) begin
          @(posedge CLK); #1;
          lf  = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
          rdy = lf[3:0];
          cyc++;
        end
        if (cyc >= 600) check("t4 drain timeout", 32'd0, 32'd1);
      end
    join
    rdy = 4'h0;
    @(posedge CLK); #1;
    check("t4 retired", {24'h0, retired_count}, 32'd18);
    check("t4 empty", {31'h0, empty}, 32'd1);

    // Flush a partially sent head
    push(5'h01, 5'h02);
    rdy = 4'h3;
    @(posedge CLK); #1;
    rdy   = 4'hF;
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    rdy   = 4'h0;
    @(negedge CLK);
    check("t5 empty", {31'h0, empty}, 32'd1);
    check("t5 valids", {28'h0, vv}, 32'h0);
    check("t5 retired", {24'h0, retired_count}, 32'd18);
    @(posedge CLK); #1;
    rdy = 4'hF;
    push(5'h04, 5'h05);
    @(negedge CLK);
    check("t5 repush valids", {28'h0, vv}, 32'hF);
    @(posedge CLK); #1;
    check("t5 repush retired", {24'h0, retired_count}, 32'd19);
    rdy = 4'h0;

    // Asynchronous reset mid-fork
    push(5'h06, 5'h07);
    push(5'h08, 5'h09);
    rdy = 4'h1;
    @(posedge CLK); #1;
    rdy = 4'h0;
    #2 ASYNCRESETN = 1'b0;
    #1;
    check("t6 valids", {28'h0, vv}, 32'h0);
    check("t6 in_ready", {31'h0, hs.in_ready}, 32'd0);
    check("t6 retired", {24'h0, retired_count}, 32'd0);
    check("t6 empty", {31'h0, empty}, 32'd1);
    @(posedge CLK); #1;
    @(posedge CLK); #3;
    ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    check("t6 empty after", {31'h0, empty}, 32'd1);
    check("t6 in_ready after", {31'h0, hs.in_ready}, 32'd1);
    rdy = 4'hF;
    push(5'h0A, 5'h0B);
    @(negedge CLK);
    check("t6 out_data", {22'h0, hs.out_data}, 32'h16A);
    @(posedge CLK); #1;
    check("t6 retired after", {24'h0, retired_count}, 32'd1);
    rdy = 4'h0;
    @(posedge CLK); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
